// File: rtl/aq_spsram_64x98_ctrl.sv
// Request front-end for the 64x98 single-port SRAM: zero-fills the array after reset,
// then serves valid/ready reads and writes and returns read data through a 2-entry buffer.
module aq_spsram_64x98_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 98,
  parameter int DEPTH      = 64
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    init_done_q;
  logic                    rd_inflight_q;
  logic [1:0]              fill_q;
  logic [DATA_WIDTH-1:0]   head_q;
  logic [DATA_WIDTH-1:0]   tail_q;

  logic                    pop;
  logic                    push;
  logic [2:0]              occ_after_pop;
  logic                    accept;
  logic                    accept_rd;

  assign rsp_vld   = (fill_q != 2'd0);
  assign rsp_rdata = head_q;
  assign init_done = init_done_q;

  // Occupancy counts the read already in flight, since it lands in the buffer next edge.
  assign pop           = rsp_vld & rsp_rdy;
  assign push          = rd_inflight_q;
  assign occ_after_pop = {1'b0, fill_q} - {2'b0, pop} + {2'b0, rd_inflight_q};
  assign req_rdy       = init_done_q & (req_wr | (occ_after_pop < 3'd2));
  assign accept        = req_vld & req_rdy;
  assign accept_rd     = accept & ~req_wr;

  // NOTE: every output is given a default first so no path through the block infers a latch.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b0;
    sram_a    = '0;
    sram_d    = '0;
    sram_wen  = '0;
    if (state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b1;
      sram_a    = init_cnt_q;
      sram_wen  = '1;
    end else if (accept) begin
      sram_cen  = 1'b0;
      sram_a    = req_addr;
      sram_gwen = req_wr;
      if (req_wr) begin
        sram_d   = req_wdata;
        sram_wen = req_wmask;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      fill_q        <= 2'd0;
      // NOTE: the buffer data is reset too, because rsp_rdata is visible and must read 0 after reset.
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: ;
      endcase

      rd_inflight_q <= accept_rd;

      // Head always holds the oldest entry; tail only matters when two are held.
      case (fill_q)
        2'd0: begin
          if (push) begin
            head_q <= sram_q;
            fill_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= sram_q;
          end else if (push) begin
            tail_q <= sram_q;
            fill_q <= 2'd2;
          end else if (pop) begin
            fill_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= sram_q;
            end else begin
              fill_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_spsram_64x98_ctrl.sv
// Bench for aq_spsram_64x98_ctrl: behavioural SRAM, reference memory and an in-order
// response scoreboard fed from accepted reads.
module tb_aq_spsram_64x98_ctrl;

  localparam int AW = 6;
  localparam int DW = 98;

  logic          clk;
  logic          cpurst;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic [DW-1:0] sram_d;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_q;

  int vectors;
  int miscompares;

  logic [DW-1:0] sram_mem [64];
  logic [DW-1:0] ref_mem  [64];
  logic [DW-1:0] exp_q [$];

  aq_spsram_64x98_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst        (cpurst),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_rdata     (rsp_rdata),
    .init_done     (init_done),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_d        (sram_d),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_q        (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Behavioural single-port SRAM, 1-cycle read latency, bitwise write enable.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // Scoreboard: accepted reads push the reference value, popped responses are compared.
  always @(negedge clk) begin
    if (!cpurst && req_vld && req_rdy) begin
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      else        exp_q.push_back(ref_mem[req_addr]);
    end
    if (rsp_vld && rsp_rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got %h with no read outstanding", rsp_rdata);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          miscompares++;
          $display("FAIL rsp_data: got %h expected %h", rsp_rdata, e);
        end
      end
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    bit ok;
    ok        = 1'b0;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wmask = wm;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_rdy;
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: addr %h wr %0b never accepted, required accept within 200 cycles", addr, wr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !rsp_vld) break;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (exp_q.size() != 0 || rsp_vld) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_sweep();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      vectors++;
      if ({sram_cen, sram_gwen, sram_a, sram_d, sram_wen, init_done, req_rdy} !==
          {1'b0, 1'b1, AW'(i), {DW{1'b0}}, {DW{1'b1}}, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL sweep_%0d: cen=%b gwen=%b a=%0d d=%h wen=%h done=%b rdy=%b, required cen=0 gwen=1 a=%0d d=0 wen=all1 done=0 rdy=0",
                 i, sram_cen, sram_gwen, sram_a, sram_d, sram_wen, init_done, req_rdy, i);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if ({init_done, req_rdy, sram_cen} !== 3'b111) begin
      miscompares++;
      $display("FAIL init_done: done=%b rdy=%b cen=%b, required 1 1 1", init_done, req_rdy, sram_cen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({init_done, req_rdy, rsp_vld} !== 3'b000 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_state: done=%b rdy=%b vld=%b rdata=%h, required all 0", init_done, req_rdy, rsp_vld, rsp_rdata);
    end
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    clear_ref();
    check_sweep();
    issue(1'b0, 6'h3F, '0, '0);
    drain();
  endtask

  task automatic test_raw();
    logic [DW-1:0] d;
    d = 98'h3_FFFF_0000_1234_5678_9ABC_DEF0;
    rsp_rdy = 1'b1;
    issue(1'b1, 6'h05, d, '1);
    issue(1'b0, 6'h05, '0, '0);
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_latency1: rsp_vld=%b one cycle after accept, required 0", rsp_vld);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_rdata !== d) begin
      miscompares++;
      $display("FAIL raw_latency2: rsp_vld=%b rdata=%h, required 1 %h", rsp_vld, rsp_rdata, d);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_mask();
    issue(1'b1, 6'h0A, '1, '1);
    req_vld   = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 6'h0A;
    req_wdata = '0;
    req_wmask = 98'h1;
    @(negedge clk);
    vectors++;
    if ({req_rdy, sram_cen, sram_gwen, sram_a} !== {3'b101, 6'h0A} || sram_wen !== 98'h1 || sram_d !== '0) begin
      miscompares++;
      $display("FAIL mask_pins: rdy=%b cen=%b gwen=%b a=%h wen=%h, required 1 0 1 0a wen=1", req_rdy, sram_cen, sram_gwen, sram_a, sram_wen);
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    issue(1'b0, 6'h0A, '0, '0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_rdata !== 98'h3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL mask_data: rdata=%h, required 3ffffffffffffffffffffffffe", rsp_rdata);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pat [5];
    for (int i = 1; i <= 4; i++) begin
      pat[i] = rand_word();
      issue(1'b1, AW'(i), pat[i], '1);
    end
    rsp_rdy = 1'b0;
    issue(1'b0, 6'd1, '0, '0);
    issue(1'b0, 6'd2, '0, '0);
    req_vld  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 6'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (req_rdy !== 1'b0 || (i > 0 && (rsp_vld !== 1'b1 || rsp_rdata !== pat[1]))) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: rdy=%b vld=%b rdata=%h, required rdy=0 vld=1 rdata=%h", i, req_rdy, rsp_vld, rsp_rdata, pat[1]);
      end
      @(posedge clk);
      #1;
    end
    req_wr    = 1'b1;
    req_addr  = 6'h07;
    req_wdata = rand_word();
    req_wmask = '1;
    @(negedge clk);
    vectors++;
    if (req_rdy !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_write: rdy=%b cen=%b gwen=%b with buffer full, required 1 0 1", req_rdy, sram_cen, sram_gwen);
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    issue(1'b0, 6'd3, '0, '0);
    issue(1'b0, 6'd4, '0, '0);
    issue(1'b0, 6'h07, '0, '0);
    drain();
  endtask

  task automatic test_back_to_back();
    int accepts;
    int nvld;
    int rises;
    logic prev;
    for (int i = 0; i < 10; i++) issue(1'b1, AW'(20 + i), rand_word(), '1);
    rsp_rdy = 1'b1;
    accepts = 0;
    nvld    = 0;
    rises   = 0;
    prev    = rsp_vld;
    for (int i = 0; i < 14; i++) begin
      req_vld  = (i < 10);
      req_wr   = 1'b0;
      req_addr = AW'(20 + i);
      @(negedge clk);
      if (i < 10 && req_rdy) accepts++;
      if (rsp_vld) begin
        nvld++;
        if (!prev) rises++;
      end
      prev = rsp_vld;
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
    vectors++;
    if (accepts != 10 || nvld != 10 || rises != 1) begin
      miscompares++;
      $display("FAIL stream: accepts=%0d vld_cycles=%0d bursts=%0d, required 10 10 1", accepts, nvld, rises);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 6'h05, rand_word() | 98'h1, '1);
    rsp_rdy = 1'b0;
    issue(1'b0, 6'h05, '0, '0);
    issue(1'b0, 6'h0A, '0, '0);
    cpurst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: rsp_vld=%b with one buffered entry, required 1", rsp_vld);
    end
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    exp_q.delete();
    clear_ref();
    @(negedge clk);
    vectors++;
    if ({rsp_vld, init_done, req_rdy} !== 3'b000 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL mid_flush: vld=%b done=%b rdy=%b rdata=%h, required 0 0 0 0", rsp_vld, init_done, req_rdy, rsp_rdata);
    end
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_stale: rsp_vld=%b after reset, required 0", rsp_vld);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 80 && !init_done; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_sweep: init_done=%b after restart, required 1", init_done);
    end
    issue(1'b0, 6'h05, '0, '0);
    issue(1'b0, 6'h0A, '0, '0);
    drain();
  endtask

  task automatic test_restart_sweep();
    cpurst = 1'b1;
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    clear_ref();
    check_sweep();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cpurst      = 1'b1;
    req_vld     = 1'b0;
    req_wr      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wmask   = '0;
    rsp_rdy     = 1'b1;
    sram_q      = rand_word();
    for (int i = 0; i < 64; i++) sram_mem[i] = rand_word();
    test_reset();
    test_raw();
    test_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    issue(1'b1, 6'h11, rand_word(), '1);
    test_restart_sweep();
    issue(1'b0, 6'h11, '0, '0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
